// File: rtl/fpu_job_scheduler_if.sv
// ============================================================================
// Module      : fpu_job_scheduler_if
// Description : Job, unit-control and completion bundle for fpu_job_scheduler.
//               The slave modport is the scheduler. The master modport is the
//               host together with the FPU units it drives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_job_scheduler_if #(
  parameter int NUM_UNITS = 4,
  parameter int TAG_W     = 8
);
  localparam int C_UW = $clog2(NUM_UNITS);

  logic                 job_valid;
  logic                 job_ready;
  logic [C_UW-1:0]      job_unit;
  logic [TAG_W-1:0]     job_tag;
  logic [NUM_UNITS-1:0] unit_go;
  logic [NUM_UNITS-1:0] unit_done;
  logic                 cpl_valid;
  logic                 cpl_ready;
  logic [C_UW-1:0]      cpl_unit;
  logic [TAG_W-1:0]     cpl_tag;
  logic                 busy;

  modport master (
    output job_valid, job_unit, job_tag, unit_done, cpl_ready,
    input  job_ready, unit_go, cpl_valid, cpl_unit, cpl_tag, busy
  );

  modport slave (
    input  job_valid, job_unit, job_tag, unit_done, cpl_ready,
    output job_ready, unit_go, cpl_valid, cpl_unit, cpl_tag, busy
  );
endinterface

`default_nettype wire

// File: rtl/fpu_job_scheduler.sv
// ============================================================================
// Module      : fpu_job_scheduler
// Description : In-order FPU job dispatcher. Jobs queue in a FIFO and issue
//               to NUM_UNITS single-job units (go pulse, level done). Finished
//               units are returned through a round-robin completion port.
//               Jobs for a non-existent unit complete via an error slot.
//               Optional macro FPU_SCHED_PERF_EN adds performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_job_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_l,
  fpu_job_scheduler_if.slave      bus
`ifdef FPU_SCHED_PERF_EN
  ,
  input  logic                    perf_clr_i,
  output logic [95:0]             perf_cnt_o
`endif
);

  localparam int C_UW  = $clog2(NUM_UNITS);
  localparam int C_UW1 = C_UW + 1;
  localparam int C_AW  = $clog2(DEPTH);
  localparam int C_PW  = C_AW + 1;
  localparam int C_EW  = C_UW + TAG_W;
  localparam logic [C_UW:0]   C_NUM_EXT = C_UW1'(NUM_UNITS);
  localparam logic [C_UW-1:0] C_LAST    = C_UW'(NUM_UNITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CPLT = 2'd2
  } unit_state_t;

  // FIFO storage and wrap-bit pointers
  logic [C_EW-1:0]      fifo_mem_q [DEPTH];
  logic [C_PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [C_PW-1:0]      rd_ptr_q, rd_ptr_d;

  // Per-unit state
  unit_state_t          state_q [NUM_UNITS];
  unit_state_t          state_d [NUM_UNITS];
  logic [TAG_W-1:0]     tag_q   [NUM_UNITS];
  logic [NUM_UNITS-1:0] done_prev_q;

  // Error slot for jobs addressed to a unit that does not exist
  logic                 err_pend_q, err_pend_d;
  logic [C_UW-1:0]      err_unit_q;
  logic [TAG_W-1:0]     err_tag_q;

  // Registered outputs and arbitration state
  logic                 job_ready_q;
  logic                 busy_q;
  logic [NUM_UNITS-1:0] unit_go_q;
  logic                 cpl_valid_q;
  logic                 cpl_err_q;
  logic [C_UW-1:0]      cpl_unit_q;
  logic [TAG_W-1:0]     cpl_tag_q;
  logic [C_UW-1:0]      rr_q;

  // Combinational
  logic                 w_empty, w_push, w_head_vld, w_head_err, w_head_free;
  logic                 w_issue, w_pop, w_wr, w_full_d, w_busy_d, w_accept;
  logic                 w_err_cand, w_load;
  logic [C_EW-1:0]      w_head;
  logic [C_UW-1:0]      w_head_unit;
  logic [TAG_W-1:0]     w_head_tag;
  logic [NUM_UNITS-1:0] w_issue_vec, w_rise, w_shown, w_cand, w_nidle_d;
  logic                 w_gnt_vld, w_gnt_err;
  logic [C_UW-1:0]      w_gnt_idx, w_rr_nxt;

  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_push   = bus.job_valid & job_ready_q;
  assign w_accept = cpl_valid_q & bus.cpl_ready;
  assign w_rise   = bus.unit_done & ~done_prev_q;

  // With an empty FIFO the incoming job is the head, so it can issue on the
  // cycle it is pushed without first being written into storage.
  assign w_head_vld  = ~w_empty | w_push;
  assign w_head      = w_empty ? {bus.job_unit, bus.job_tag}
                               : fifo_mem_q[rd_ptr_q[C_AW-1:0]];
  assign w_head_unit = w_head[C_EW-1:TAG_W];
  assign w_head_tag  = w_head[TAG_W-1:0];
  assign w_head_err  = ({1'b0, w_head_unit} >= C_NUM_EXT);

  // Head may issue only if its destination (unit or error slot) is free
  always_comb begin
    w_head_free = 1'b0;
    if (w_head_err) w_head_free = ~err_pend_q;
    else            w_head_free = (state_q[w_head_unit] == S_IDLE);
  end

  assign w_issue  = w_head_vld & w_head_free;
  assign w_pop    = w_issue & ~w_empty;
  assign w_wr     = w_push & ~(w_empty & w_issue);
  assign rd_ptr_d = rd_ptr_q + C_PW'(w_pop);
  assign wr_ptr_d = wr_ptr_q + C_PW'(w_wr);
  assign w_full_d = (wr_ptr_d[C_AW] != rd_ptr_d[C_AW]) &&
                    (wr_ptr_d[C_AW-1:0] == rd_ptr_d[C_AW-1:0]);

  // Decode issue to a one-hot go vector
  always_comb begin
    w_issue_vec = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_issue_vec[i] = w_issue & ~w_head_err & (w_head_unit == C_UW'(i));
    end
  end

  // Unit next-state; a done edge in RUN is offered to the arbiter at once
  always_comb begin
    w_shown   = '0;
    w_cand    = '0;
    w_nidle_d = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_shown[i]  = cpl_valid_q & ~cpl_err_q & (cpl_unit_q == C_UW'(i));
      state_d[i]  = state_q[i];
      case (state_q[i])
        S_IDLE:  if (w_issue_vec[i])          state_d[i] = S_RUN;
        S_RUN:   if (w_rise[i])               state_d[i] = S_CPLT;
        S_CPLT:  if (w_accept && w_shown[i])  state_d[i] = S_IDLE;
        default:                              state_d[i] = S_IDLE;
      endcase
      w_cand[i]    = ((state_q[i] == S_CPLT) & ~w_shown[i]) |
                     ((state_q[i] == S_RUN) & w_rise[i]);
      w_nidle_d[i] = (state_d[i] != S_IDLE);
    end
  end

  // Error slot is set on an error issue and freed when its completion is taken
  always_comb begin
    err_pend_d = err_pend_q;
    if (w_issue && w_head_err)        err_pend_d = 1'b1;
    else if (w_accept && cpl_err_q)   err_pend_d = 1'b0;
  end

  assign w_busy_d   = (wr_ptr_d != rd_ptr_d) | (|w_nidle_d) | err_pend_d;
  assign w_err_cand = err_pend_q & ~(cpl_valid_q & cpl_err_q);
  assign w_load     = ~cpl_valid_q | bus.cpl_ready;

  // Round-robin grant starting at rr_q; error slot only when no unit wants it
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_err = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!w_gnt_vld && w_cand[(int'(rr_q) + k) % NUM_UNITS]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = C_UW'((int'(rr_q) + k) % NUM_UNITS);
      end
    end
    if (!w_gnt_vld && w_err_cand) begin
      w_gnt_vld = 1'b1;
      w_gnt_err = 1'b1;
    end
  end

  assign w_rr_nxt = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + C_UW'(1);

  // FIFO storage write; contents need no reset since pointers qualify them
  always_ff @(posedge clk) begin
    if (w_wr) fifo_mem_q[wr_ptr_q[C_AW-1:0]] <= {bus.job_unit, bus.job_tag};
  end

  // Queue pointers, unit states, slots and status outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      unit_go_q   <= '0;
      done_prev_q <= '0;
      err_pend_q  <= 1'b0;
      err_unit_q  <= '0;
      err_tag_q   <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        state_q[i] <= S_IDLE;
        tag_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      job_ready_q <= ~w_full_d;
      busy_q      <= w_busy_d;
      unit_go_q   <= w_issue_vec;
      done_prev_q <= bus.unit_done;
      err_pend_q  <= err_pend_d;
      if (w_issue && w_head_err) begin
        err_unit_q <= w_head_unit;
        err_tag_q  <= w_head_tag;
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
        state_q[i] <= state_d[i];
        if (w_issue_vec[i]) tag_q[i] <= w_head_tag;
      end
    end
  end

  // Completion register; reloads only when empty or being accepted
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cpl_valid_q <= 1'b0;
      cpl_err_q   <= 1'b0;
      cpl_unit_q  <= '0;
      cpl_tag_q   <= '0;
      rr_q        <= '0;
    end else if (w_load) begin
      cpl_valid_q <= w_gnt_vld;
      if (w_gnt_vld) begin
        cpl_err_q  <= w_gnt_err;
        cpl_unit_q <= w_gnt_err ? err_unit_q : w_gnt_idx;
        cpl_tag_q  <= w_gnt_err ? err_tag_q  : tag_q[w_gnt_idx];
        if (!w_gnt_err) rr_q <= w_rr_nxt;
      end
    end
  end

  assign bus.job_ready = job_ready_q;
  assign bus.busy      = busy_q;
  assign bus.unit_go   = unit_go_q;
  assign bus.cpl_valid = cpl_valid_q;
  assign bus.cpl_unit  = cpl_unit_q;
  assign bus.cpl_tag   = cpl_tag_q;

`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_iss_q, perf_cpl_q, perf_stall_q;
  logic        w_stall;

  assign w_stall = ~w_empty & ~w_issue;

  // Saturating event counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      perf_iss_q   <= '0;
      perf_cpl_q   <= '0;
      perf_stall_q <= '0;
    end else if (perf_clr_i) begin
      perf_iss_q   <= '0;
      perf_cpl_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (w_issue  && (perf_iss_q   != '1)) perf_iss_q   <= perf_iss_q + 32'd1;
      if (w_accept && (perf_cpl_q   != '1)) perf_cpl_q   <= perf_cpl_q + 32'd1;
      if (w_stall  && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cnt_o = {perf_stall_q, perf_cpl_q, perf_iss_q};
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_job_scheduler.sv
// ============================================================================
// Module      : tb_fpu_job_scheduler
// Description : Scoreboard bench for fpu_job_scheduler. Expected go pulses
//               and completions are queued as jobs are pushed; monitors pop
//               and compare when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_job_scheduler;

  logic clk;
  logic rst_l;

  typedef struct packed {
    logic [1:0] u;
    logic [7:0] t;
  } job_t;

  job_t exp_go[$];
  job_t exp_cpl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  fpu_job_scheduler_if #(.NUM_UNITS(4), .TAG_W(8)) bus ();

`ifdef FPU_SCHED_PERF_EN
  logic        perf_clr;
  logic [95:0] perf_cnt;
  initial perf_clr = 1'b0;
`endif

  fpu_job_scheduler #(.NUM_UNITS(4), .DEPTH(8), .TAG_W(8)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
`ifdef FPU_SCHED_PERF_EN
    ,
    .perf_clr_i (perf_clr),
    .perf_cnt_o (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] u, input logic [7:0] t);
    bus.job_valid = 1'b1;
    bus.job_unit  = u;
    bus.job_tag   = t;
    exp_go.push_back('{u: u, t: t});
    exp_cpl.push_back('{u: u, t: t});
    tick(1);
    bus.job_valid = 1'b0;
  endtask

  task automatic pulse_done(input int u);
    bus.unit_done[u] = 1'b1;
    tick(1);
    bus.unit_done[u] = 1'b0;
  endtask

  task automatic chk_reset(input string tagname);
    chk({tagname, "_job_ready"}, 32'(bus.job_ready), 32'd1);
    chk({tagname, "_busy"},      32'(bus.busy),      32'd0);
    chk({tagname, "_unit_go"},   32'(bus.unit_go),   32'd0);
    chk({tagname, "_cpl_valid"}, 32'(bus.cpl_valid), 32'd0);
    chk({tagname, "_cpl_unit"},  32'(bus.cpl_unit),  32'd0);
    chk({tagname, "_cpl_tag"},   32'(bus.cpl_tag),   32'd0);
  endtask

  // Go monitor: every pulse must match the next expected issue, one-hot
  always @(negedge clk) begin
    if (bus.unit_go != 4'b0000) begin
      if (exp_go.size() == 0) begin
        chk("go_unexpected", 32'(bus.unit_go), 32'd0);
      end else begin
        job_t e;
        e = exp_go.pop_front();
        chk("go_order", 32'(bus.unit_go), 32'(4'b0001 << e.u));
      end
    end
  end

  // Completion monitor: each accepted completion is compared in order
  always @(negedge clk) begin
    if (bus.cpl_valid && bus.cpl_ready) begin
      if (exp_cpl.size() == 0) begin
        chk("cpl_unexpected", {22'd0, bus.cpl_unit, bus.cpl_tag}, 32'hFFFF_FFFF);
      end else begin
        job_t e;
        e = exp_cpl.pop_front();
        chk("cpl_unit_tag", {22'd0, bus.cpl_unit, bus.cpl_tag}, {22'd0, e.u, e.t});
      end
    end
  end

  initial begin
    rst_l         = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_unit  = '0;
    bus.job_tag   = '0;
    bus.unit_done = '0;
    bus.cpl_ready = 1'b1;
    tick(2);
    chk_reset("rst");
    rst_l = 1'b1;
    tick(2);

    // Single job: go one cycle after push, completion one cycle after done
    push(2'd1, 8'h5A);
    chk("single_go_latency", 32'(bus.unit_go), 32'h2);
    chk("single_busy", 32'(bus.busy), 32'd1);
    tick(9);
    bus.unit_done[1] = 1'b1;
    tick(1);
    chk("single_cpl_valid", 32'(bus.cpl_valid), 32'd1);
    chk("single_cpl_unit", 32'(bus.cpl_unit), 32'd1);
    chk("single_cpl_tag", 32'(bus.cpl_tag), 32'h5A);
    bus.unit_done[1] = 1'b0;
    tick(1);
    chk("single_busy_drop", 32'(bus.busy), 32'd0);

    // Head-of-line blocking: unit 2 job waits behind the second unit 0 job
    push(2'd0, 8'h01);
    push(2'd0, 8'h02);
    push(2'd2, 8'h03);
    tick(5);
    chk("hol_no_cpl", 32'(bus.cpl_valid), 32'd0);
    chk("hol_busy", 32'(bus.busy), 32'd1);
    chk("hol_no_go", 32'(bus.unit_go), 32'd0);
    pulse_done(0);
    tick(2);
    chk("hol_t2_go", 32'(bus.unit_go), 32'h1);
    tick(1);
    chk("hol_t3_go", 32'(bus.unit_go), 32'h4);
    tick(3);
    pulse_done(0);
    tick(3);
    pulse_done(2);
    tick(3);
    chk("hol_idle", 32'(bus.busy), 32'd0);

    // Simultaneous completions from reset pointer: 0, 1, 3
    rst_l = 1'b0;
    tick(1);
    rst_l = 1'b1;
    tick(1);
    push(2'd0, 8'hA0);
    push(2'd1, 8'hB1);
    push(2'd3, 8'hC3);
    tick(2);
    bus.unit_done = 4'b1011;
    tick(1);
    bus.unit_done = 4'b0000;
    chk("sim0_first", {31'd0, bus.cpl_valid} | (32'(bus.cpl_unit) << 4), 32'h01);
    tick(1);
    chk("sim0_second", {31'd0, bus.cpl_valid} | (32'(bus.cpl_unit) << 4), 32'h11);
    tick(1);
    chk("sim0_third", {31'd0, bus.cpl_valid} | (32'(bus.cpl_unit) << 4), 32'h31);
    tick(1);
    chk("sim0_drained", 32'(bus.cpl_valid), 32'd0);

    // Move the last grant to unit 1, then expect 3, 0, 1 with backpressure
    push(2'd1, 8'h44);
    tick(2);
    pulse_done(1);
    tick(3);
    bus.cpl_ready = 1'b0;
    push(2'd3, 8'hD3);
    push(2'd0, 8'hD0);
    push(2'd1, 8'hD1);
    tick(2);
    bus.unit_done = 4'b1011;
    tick(1);
    bus.unit_done = 4'b0000;
    chk("sim1_first", 32'(bus.cpl_unit), 32'd3);
    tick(1);
    chk("sim1_hold_valid", 32'(bus.cpl_valid), 32'd1);
    chk("sim1_hold_unit", 32'(bus.cpl_unit), 32'd3);
    chk("sim1_hold_tag", 32'(bus.cpl_tag), 32'hD3);
    bus.cpl_ready = 1'b1;
    tick(1);
    chk("sim1_second", 32'(bus.cpl_unit), 32'd0);
    tick(1);
    chk("sim1_third", 32'(bus.cpl_unit), 32'd1);
    tick(2);

    // FIFO full: unit 0 stalled, eight jobs fill the queue
    push(2'd0, 8'h10);
    for (int k = 1; k <= 8; k++) begin
      chk("full_ready_before", 32'(bus.job_ready), 32'd1);
      push(2'd0, 8'(8'h10 + k));
    end
    chk("full_ready_low", 32'(bus.job_ready), 32'd0);
    bus.job_valid = 1'b1;
    bus.job_unit  = 2'd0;
    bus.job_tag   = 8'h99;
    tick(1);
    bus.job_valid = 1'b0;
    chk("full_drop_ready", 32'(bus.job_ready), 32'd0);
    pulse_done(0);
    tick(1);
    chk("full_pop_cycle_ready", 32'(bus.job_ready), 32'd0);
    tick(1);
    chk("full_ready_back", 32'(bus.job_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick(2);
      pulse_done(0);
      tick(3);
    end
    tick(3);
    chk("full_idle", 32'(bus.busy), 32'd0);

    // Stale done: a level already high at issue must not complete the job
    bus.unit_done[2] = 1'b1;
    tick(2);
    push(2'd2, 8'h77);
    tick(5);
    chk("stale_ignored", 32'(bus.cpl_valid), 32'd0);
    bus.unit_done[2] = 1'b0;
    tick(1);
    bus.unit_done[2] = 1'b1;
    tick(1);
    chk("stale_cpl_valid", 32'(bus.cpl_valid), 32'd1);
    chk("stale_cpl_unit", 32'(bus.cpl_unit), 32'd2);
    bus.unit_done[2] = 1'b0;
    tick(2);
    chk("stale_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset with unit 0 running and three jobs queued
    push(2'd0, 8'hA1);
    push(2'd0, 8'hA2);
    push(2'd0, 8'hA3);
    push(2'd0, 8'hA4);
    tick(2);
    chk("arst_busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst_l = 1'b0;
    #1;
    chk_reset("arst");
    exp_go.delete();
    exp_cpl.delete();
    tick(1);
    rst_l = 1'b1;
    tick(10);
    chk("arst_busy_after", 32'(bus.busy), 32'd0);
    chk("arst_ready_after", 32'(bus.job_ready), 32'd1);

    chk("go_sb_drained", 32'(exp_go.size()), 32'd0);
    chk("cpl_sb_drained", 32'(exp_cpl.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
